// File: rtl/max_reduce_int64_ctrl.sv
// rtl/max_reduce_int64_ctrl.sv - streaming signed max reduction with element count
// Optional argmax output (out_idx) is enabled by defining MAX_REDUCE_ARGMAX_EN.

// Signed greater-than: gt = (a > b) in two's complement.
module gt_int_nbit #(
  parameter int WIDTH     = 64,
  parameter int IMPL_TYPE = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt
);
  generate
    if (IMPL_TYPE == 1) begin : g_split
      // Sign bits decide when they differ; otherwise the low bits order like unsigned.
      always_comb begin
        if (a[WIDTH-1] != b[WIDTH-1]) gt = b[WIDTH-1];
        else                          gt = (a[WIDTH-2:0] > b[WIDTH-2:0]);
      end
    end else begin : g_direct
      // Plain signed compare left to the synthesis tool.
      always_comb gt = ($signed(a) > $signed(b));
    end
  endgenerate
endmodule

module max_reduce_int64_ctrl #(
  parameter int WIDTH     = 64,
  parameter int IMPL_TYPE = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [CNT_W-1:0] out_count,
`ifdef MAX_REDUCE_ARGMAX_EN
  output logic [CNT_W-1:0] out_idx,
`endif
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             gt;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt_next;
`ifdef MAX_REDUCE_ARGMAX_EN
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] idx_next;
`endif

  // Single shared comparator: is the incoming element strictly larger than the running max?
  gt_int_nbit #(.WIDTH(WIDTH), .IMPL_TYPE(IMPL_TYPE)) u_gt (
    .a  (in_data),
    .b  (acc),
    .gt (gt)
  );

  // Next running max/count for an accepted element in ACCUM; ties keep the earlier element.
  always_comb begin
    acc_next = gt ? in_data : acc;
    cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
`ifdef MAX_REDUCE_ARGMAX_EN
    // cnt equals the zero-based position of the incoming element, pinned once saturated.
    idx_next = gt ? cnt : idx;
`endif
  end

  assign in_ready = (state != DONE);
  assign busy     = (state != IDLE);

  // Frame FSM: accumulate elements, then hold the result until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_max   <= '0;
      out_count <= '0;
`ifdef MAX_REDUCE_ARGMAX_EN
      idx       <= '0;
      out_idx   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc <= in_data;
            cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef MAX_REDUCE_ARGMAX_EN
            idx <= '0;
`endif
            if (in_last) begin
              out_max   <= in_data;
              out_count <= {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef MAX_REDUCE_ARGMAX_EN
              out_idx   <= '0;
`endif
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc <= acc_next;
            cnt <= cnt_next;
`ifdef MAX_REDUCE_ARGMAX_EN
            idx <= idx_next;
`endif
            if (in_last) begin
              out_max   <= acc_next;
              out_count <= cnt_next;
`ifdef MAX_REDUCE_ARGMAX_EN
              out_idx   <= idx_next;
`endif
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_max_reduce_int64_ctrl.sv
// tb/tb_max_reduce_int64_ctrl.sv - self-checking bench for max_reduce_int64_ctrl
module tb_max_reduce_int64_ctrl;
  localparam logic [63:0] SMAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SMIN = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_valid4 = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_ready4 = 1'b0;
  logic        in_ready, out_valid, busy;
  logic [63:0] out_max;
  logic [15:0] out_count;
  logic        in_ready4, out_valid4, busy4;
  logic [63:0] out_max4;
  logic [3:0]  out_count4;
`ifdef MAX_REDUCE_ARGMAX_EN
  logic [15:0] out_idx;
  logic [3:0]  out_idx4;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  max_reduce_int64_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_max(out_max), .out_count(out_count),
`ifdef MAX_REDUCE_ARGMAX_EN
    .out_idx(out_idx),
`endif
    .busy(busy)
  );

  max_reduce_int64_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid4),
    .out_ready(out_ready4), .out_max(out_max4), .out_count(out_count4),
`ifdef MAX_REDUCE_ARGMAX_EN
    .out_idx(out_idx4),
`endif
    .busy(busy4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Called just after a rising edge; returns just after the edge that transfers the element.
  task automatic push(input logic [63:0] d, input logic l);
    int n;
    in_valid = 1'b1; in_data = d; in_last = l;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) chk("push_ready_timeout", {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Checks the result one cycle after the last transfer, then accepts it.
  task automatic drain(input string name, input logic [63:0] emax, input logic [15:0] ecnt,
                       input logic [15:0] eidx);
    @(negedge clk);
    chk({name, "_valid"}, {63'b0, out_valid}, 64'd1);
    chk({name, "_max"}, out_max, emax);
    chk({name, "_count"}, {48'b0, out_count}, {48'b0, ecnt});
    chk({name, "_inready"}, {63'b0, in_ready}, 64'd0);
`ifdef MAX_REDUCE_ARGMAX_EN
    chk({name, "_idx"}, {48'b0, out_idx}, {48'b0, eidx});
`else
    if (eidx == 16'hFFFF) chk({name, "_noidx"}, 64'd0, 64'd1);
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, "_cleared"}, {62'b0, out_valid, busy}, 64'd0);
  endtask

  typedef struct {
    string       name;
    int          len;
    logic [63:0] e [5];
    logic [63:0] emax;
    logic [15:0] ecnt;
    logic [15:0] eidx;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{"single",  1, '{-64'sd5, 0, 0, 0, 0},                 -64'sd5, 16'd1, 16'd0};
    vecs[1] = '{"signed",  5, '{64'd3, -64'sd1, SMAX, SMIN, 64'd10},  SMAX,    16'd5, 16'd2};
    vecs[2] = '{"minmin",  2, '{SMIN, SMIN, 0, 0, 0},                 SMIN,    16'd2, 16'd0};
    vecs[3] = '{"zero",    3, '{-64'sd1, 64'd0, -64'sd1, 0, 0},       64'd0,   16'd3, 16'd1};
    vecs[4] = '{"desc",    5, '{64'd5, 64'd4, 64'd3, 64'd2, 64'd1},   64'd5,   16'd5, 16'd0};
    vecs[5] = '{"asc",     5, '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5},   64'd5,   16'd5, 16'd4};
    vecs[6] = '{"ties",    4, '{-64'sd100, -64'sd100, -64'sd50, -64'sd50, 0}, -64'sd50, 16'd4, 16'd2};

    // Reset state
    #12;
    chk("rst_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_max", out_max, 64'd0);
    chk("rst_count", {48'b0, out_count}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", {63'b0, in_ready}, 64'd1);

    // Table-driven frames
    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < vecs[v].len; k++) push(vecs[v].e[k], k == vecs[v].len - 1);
      drain(vecs[v].name, vecs[v].emax, vecs[v].ecnt, vecs[v].eidx);
    end

    // Ties and backpressure: result held, stray input ignored
    push(64'd7, 1'b0); push(64'd7, 1'b0); push(64'd2, 1'b1);
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin in_valid = 1'b1; in_data = 64'd99; in_last = 1'b1; end
      @(negedge clk);
      chk("stall_valid", {63'b0, out_valid}, 64'd1);
      chk("stall_max", out_max, 64'd7);
      chk("stall_inready", {63'b0, in_ready}, 64'd0);
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
    end
    drain("stall", 64'd7, 16'd3, 16'd0);

    // Input gaps, then next frame right after the output transfer
    push(-64'sd9, 1'b0);
    repeat (3) @(posedge clk); #1;
    chk("gap_busy", {63'b0, busy}, 64'd1);
    push(-64'sd2, 1'b0);
    @(posedge clk); #1;
    push(-64'sd4, 1'b1);
    drain("gaps", -64'sd2, 16'd3, 16'd1);
    push(64'd1, 1'b1);
    drain("b2b", 64'd1, 16'd1, 16'd0);

    // Asynchronous reset mid-frame
    push(64'd100, 1'b0); push(64'd200, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("amid_max", out_max, 64'd0);
    chk("amid_count", {48'b0, out_count}, 64'd0);
    chk("amid_busy", {62'b0, busy, out_valid}, 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    push(-64'sd1, 1'b1);
    drain("post_rst", -64'sd1, 16'd1, 16'd0);

    // Count saturation on the CNT_W=4 instance
    for (int i = 0; i < 20; i++) begin
      in_valid4 = 1'b1;
      in_data = (i == 17) ? 64'd50 : 64'(i - 10);
      in_last = (i == 19);
      @(posedge clk); #1;
    end
    in_valid4 = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("sat_valid", {63'b0, out_valid4}, 64'd1);
    chk("sat_max", out_max4, 64'd50);
    chk("sat_count", {60'b0, out_count4}, 64'd15);
`ifdef MAX_REDUCE_ARGMAX_EN
    chk("sat_idx", {60'b0, out_idx4}, 64'd15);
`endif
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    chk("sat_cleared", {62'b0, out_valid4, busy4}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
